cim_xbar_responder: RTL and testbench
=====================================

CIM_XBAR_RESPONDER -- requirements
Module: cim_xbar_responder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- xbar_size, 512, crossbar rows (input vector length).
- n_cols, 16, output columns computed (n_cols <= xbar_size).
- datatype_size, 4, input, weight and output element width (unsigned).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- i_wr_en, in, 1, input-buffer write strobe.
- i_wr_addr, in, $clog2(xbar_size), input-buffer row address.
- i_wr_data, in, datatype_size, input element.
- i_w_we, in, 1, weight write strobe.
- i_w_row, in, $clog2(xbar_size), weight row.
- i_w_col, in, $clog2(n_cols), weight column.
- i_w_data, in, datatype_size, weight value.
- i_start, in, 1, start MVM request.
- o_busy, out, 1, compute in progress (drives layer i_cim_busy).
- o_done, out, 1, one-cycle pulse when results are committed.
- i_rd_addr, in, $clog2(xbar_size), result column select.
- o_data, out, datatype_size, selected result.
REQ-003 The design SHALL use one clock, clk, with reset rst synchronous and active-high; no other clock or reset exists.

Function
REQ-004 State SHALL be in = {xbuf[xbar_size], W[xbar_size][n_cols], acc[n_cols], res[n_cols]}.
REQ-005 acc width SHALL be 2*datatype_size + $clog2(xbar_size); no overflow is possible.
REQ-006 The FSM SHALL have states IDLE, COMPUTE and DONE.
- IDLE -> COMPUTE on i_start.
- COMPUTE -> DONE after row counter reaches xbar_size-1.
- DONE -> IDLE unconditionally.
REQ-007 In IDLE, i_wr_en SHALL write xbuf[i_wr_addr] and i_w_we SHALL write W[i_w_row][i_w_col]; addresses out of range SHALL be ignored.
REQ-008 Input and weight writes in COMPUTE or DONE SHALL be ignored.
REQ-009 i_start accepted in IDLE SHALL clear all acc and row counter to 0.
- A write in the same cycle as i_start SHALL be committed and visible to the computation.
REQ-010 Each COMPUTE cycle with row counter r SHALL perform acc[c] += xbuf[r]*W[r][c] for all c in parallel, then r increments.
- COMPUTE SHALL last exactly xbar_size cycles.
REQ-011 In DONE, res[c] SHALL be set to min(acc[c], 2^datatype_size-1), i.e. unsigned saturation.
REQ-012 o_busy SHALL be registered and high exactly in COMPUTE and DONE: i_start at cycle T gives o_busy high T+1..T+xbar_size+1.
REQ-013 o_done SHALL be high only in the DONE cycle (T+xbar_size+1).
REQ-014 i_start while o_busy=1 SHALL be ignored, with no queuing.
REQ-015 o_data SHALL be registered: o_data(t+1) = res[i_rd_addr(t)], or 0 if i_rd_addr >= n_cols.
- Reads are permitted in every state.
- During COMPUTE, reads SHALL return previous results.
- New results SHALL be readable from the DONE cycle onward, appearing on o_data one cycle later.
REQ-016 Back-to-back operation SHALL be allowed: i_start in the IDLE cycle immediately after DONE is accepted.

Reset
REQ-017 When rst=1 at a clock edge:
- FSM SHALL go to IDLE and row counter to 0.
- o_busy, o_done and o_data SHALL go to 0.
- xbuf, acc and res SHALL be cleared to 0.
- W SHALL be retained (not reset).
REQ-018 Reset SHALL take priority over i_start, writes and any in-progress COMPUTE; an aborted computation commits nothing.

Verification (xbar_size=8, n_cols=4, datatype_size=4)
REQ-019 Reset: assert rst 2 cycles -> o_busy=0, o_done=0, o_data=0 for every i_rd_addr.
REQ-020 Basic MVM:
- Stimulus: W[r][0]=1 for all r, other weights 0; xbuf={3,0,0,0,0,0,0,2}; i_start at T.
- Response: o_busy high T+1..T+9; o_done at T+9; reads give col0=5, col1..3=0.
REQ-021 Saturation:
- Stimulus: all W=15, all xbuf=15; start.
- Response: acc=1800; all res=15.
REQ-022 Busy guards:
- Stimulus: during COMPUTE pulse i_start, write xbuf[0]=9, write W[0][0]=9.
- Response: o_busy window unchanged at 9 cycles; results equal the REQ-020 values.
- A second run after IDLE still gives col0=5.
REQ-023 Same-cycle write+start:
- Stimulus: i_wr_en addr 1 data 4 together with i_start, using REQ-020 weights.
- Response: col0=9.
REQ-024 Reset mid-compute and out-of-range read:
- Stimulus: rst at T+4.
- Response: o_busy=0 next cycle; o_done never pulses; res stays 0; i_rd_addr=6 -> o_data=0.

Source files
------------

// File: rtl/cim_xbar_responder.sv
// Compute-in-memory crossbar responder: buffers an input vector and a weight matrix,
// runs one row per cycle of multiply-accumulate across all columns, and saturates the results.
module cim_xbar_responder #(
    parameter int xbar_size     = 512,
    parameter int n_cols        = 16,
    parameter int datatype_size = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr_en,
    input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
    input  logic [datatype_size-1:0]     i_wr_data,
    input  logic                         i_w_we,
    input  logic [$clog2(xbar_size)-1:0] i_w_row,
    input  logic [$clog2(n_cols)-1:0]    i_w_col,
    input  logic [datatype_size-1:0]     i_w_data,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
    output logic [datatype_size-1:0]     o_data
);

    localparam int RW = $clog2(xbar_size);
    localparam int CW = $clog2(n_cols);
    localparam int DW = datatype_size;
    localparam int PW = 2 * DW;
    localparam int AW = 2 * DW + RW;
    localparam logic [RW-1:0] LAST_ROW = RW'(xbar_size - 1);
    localparam logic [DW-1:0] MAX_VAL  = {DW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t        state_q;
    logic [RW-1:0] row_q;
    logic          busy_q;
    logic          done_q;

    logic [DW-1:0] xbuf_q [xbar_size];
    logic [DW-1:0] w_q    [xbar_size][n_cols];
    logic [AW-1:0] acc_q  [n_cols];
    logic [AW-1:0] acc_d  [n_cols];
    logic [PW-1:0] prod_d [n_cols];
    logic [DW-1:0] res_q  [n_cols];
    logic [DW-1:0] o_data_q;
    logic [DW-1:0] rd_data_d;

    logic in_idle;
    logic xbuf_wr;
    logic w_wr;
    logic start_acc;
    logic rd_in_range;

    function automatic logic [DW-1:0] sat_unsigned(input logic [AW-1:0] a);
        return (a > AW'(MAX_VAL)) ? MAX_VAL : a[DW-1:0];
    endfunction

    assign in_idle     = (state_q == IDLE);
    assign start_acc   = in_idle && i_start;
    assign xbuf_wr     = in_idle && i_wr_en && (int'(i_wr_addr) < xbar_size);
    assign w_wr        = in_idle && i_w_we && !rst
                         && (int'(i_w_row) < xbar_size) && (int'(i_w_col) < n_cols);
    assign rd_in_range = (int'(i_rd_addr) < n_cols);

    // One crossbar row per cycle: every column accumulates its product in parallel.
    always_comb begin
        for (int c = 0; c < n_cols; c++) begin
            prod_d[c] = PW'(xbuf_q[row_q]) * PW'(w_q[row_q][c]);
            acc_d[c]  = acc_q[c] + AW'(prod_d[c]);
        end
    end

    // In DONE the fresh saturated accumulator is forwarded so new results are visible a cycle early.
    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) begin
            if (state_q == DONE) begin
                rd_data_d = sat_unsigned(acc_q[i_rd_addr[CW-1:0]]);
            end else begin
                rd_data_d = res_q[i_rd_addr[CW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        state_q <= COMPUTE;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                COMPUTE: begin
                    row_q <= row_q + RW'(1);
                    if (row_q == LAST_ROW) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < xbar_size; r++) begin
                xbuf_q[r] <= '0;
            end
            for (int c = 0; c < n_cols; c++) begin
                acc_q[c] <= '0;
                res_q[c] <= '0;
            end
            o_data_q <= '0;
        end else begin
            if (xbuf_wr) begin
                xbuf_q[i_wr_addr] <= i_wr_data;
            end
            for (int c = 0; c < n_cols; c++) begin
                if (start_acc) begin
                    acc_q[c] <= '0;
                end else if (state_q == COMPUTE) begin
                    acc_q[c] <= acc_d[c];
                end
                if (state_q == DONE) begin
                    res_q[c] <= sat_unsigned(acc_q[c]);
                end
            end
            o_data_q <= rd_data_d;
        end
    end

    // Weights are deliberately kept across reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            w_q[i_w_row][i_w_col] <= i_w_data;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_data = o_data_q;

endmodule

// File: tb/tb_cim_xbar_responder.sv
// Self-checking bench for cim_xbar_responder: table vectors, hand-written corner sequences,
// and randomized matrices checked against a plain-arithmetic matrix-vector model.
module tb_cim_xbar_responder;

    localparam int XS = 8;
    localparam int NC = 4;
    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_wr_en = 1'b0;
    logic [2:0] i_wr_addr = '0;
    logic [3:0] i_wr_data = '0;
    logic       i_w_we = 1'b0;
    logic [2:0] i_w_row = '0;
    logic [1:0] i_w_col = '0;
    logic [3:0] i_w_data = '0;
    logic       i_start = 1'b0;
    logic       o_busy;
    logic       o_done;
    logic [2:0] i_rd_addr = '0;
    logic [3:0] o_data;

    cim_xbar_responder #(
        .xbar_size    (XS),
        .n_cols       (NC),
        .datatype_size(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_wr_en  (i_wr_en),
        .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data),
        .i_w_we   (i_w_we),
        .i_w_row  (i_w_row),
        .i_w_col  (i_w_col),
        .i_w_data (i_w_data),
        .i_start  (i_start),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .i_rd_addr(i_rd_addr),
        .o_data   (o_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [31:0]  x;    // nibble r = xbuf[r]
        logic [127:0] w;    // nibble 4*r+c = W[r][c]
        logic [15:0]  exp;  // nibble c = result column c
    } vec_t;

    vec_t tbl[4];

    int nvec = 0;
    int nerr = 0;

    int xb_m [XS];
    int w_m  [XS][NC];
    int res_m[NC];
    int new_m[NC];

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_calc();
        for (int c = 0; c < NC; c++) begin
            int sum = 0;
            for (int r = 0; r < XS; r++) sum += xb_m[r] * w_m[r][c];
            new_m[c] = (sum > 15) ? 15 : sum;
        end
    endfunction

    function automatic logic [15:0] model_exp();
        logic [15:0] e;
        for (int c = 0; c < NC; c++) e[4*c +: 4] = 4'(res_m[c]);
        return e;
    endfunction

    task automatic load(input logic [31:0] x, input logic [127:0] w);
        for (int r = 0; r < XS; r++) begin
            for (int c = 0; c < NC; c++) begin
                i_w_we   = 1'b1;
                i_w_row  = 3'(r);
                i_w_col  = 2'(c);
                i_w_data = w[4*(4*r+c) +: 4];
                w_m[r][c] = int'(w[4*(4*r+c) +: 4]);
                i_wr_en   = (c == 0);
                i_wr_addr = 3'(r);
                i_wr_data = x[4*r +: 4];
                if (c == 0) xb_m[r] = int'(x[4*r +: 4]);
                step();
            end
        end
        i_w_we  = 1'b0;
        i_wr_en = 1'b0;
    endtask

    task automatic check_reads(input logic [15:0] e, input string nm);
        for (int a = 0; a < 8; a++) begin
            i_rd_addr = 3'(a);
            step();
            chk($sformatf("%s rd%0d", nm, a), int'(o_data), (a < NC) ? int'(e[4*a +: 4]) : 0);
        end
    endtask

    // Leaves the caller in the IDLE cycle right after DONE.
    task automatic start_run(input bit guard, input bit same_wr, input string nm);
        int old0;
        old0      = res_m[0];
        i_rd_addr = 3'd0;
        i_start   = 1'b1;
        if (same_wr) begin
            i_wr_en   = 1'b1;
            i_wr_addr = 3'd1;
            i_wr_data = 4'd4;
            xb_m[1]   = 4;
        end
        model_calc();
        for (int n = 1; n <= 10; n++) begin
            step();
            if (n == 1) begin
                i_start = 1'b0;
                i_wr_en = 1'b0;
            end
            chk($sformatf("%s busy@%0d", nm, n), int'(o_busy), (n <= 9) ? 1 : 0);
            chk($sformatf("%s done@%0d", nm, n), int'(o_done), (n == 9) ? 1 : 0);
            chk($sformatf("%s data@%0d", nm, n), int'(o_data), (n == 10) ? new_m[0] : old0);
            if (guard && n == 3) begin
                i_start   = 1'b1;
                i_wr_en   = 1'b1;
                i_wr_addr = 3'd0;
                i_wr_data = 4'd9;
                i_w_we    = 1'b1;
                i_w_row   = 3'd0;
                i_w_col   = 2'd0;
                i_w_data  = 4'd9;
            end else if (guard && n == 4) begin
                i_start = 1'b0;
                i_wr_en = 1'b0;
                i_w_we  = 1'b0;
            end
        end
        for (int c = 0; c < NC; c++) res_m[c] = new_m[c];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, nvec=%0d nerr=%0d", nvec, nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  rx;
        logic [127:0] rw;
        bit           saw_done;
        bit           saw_busy;

        tbl[0] = '{"basic", 32'h2000_0003, {8{16'h0001}}, 16'h0005};
        tbl[1] = '{"sat",   32'hFFFF_FFFF, {8{16'hFFFF}}, 16'hFFFF};
        tbl[2] = '{"ramp",  32'h1111_1111, {8{16'h3210}}, 16'hFF80};
        tbl[3] = '{"two",   32'h0000_0021, {8{16'h4321}}, 16'hC963};

        for (int r = 0; r < XS; r++) xb_m[r] = 0;
        for (int c = 0; c < NC; c++) res_m[c] = 0;

        // Reset held for two cycles.
        rst = 1'b1;
        step();
        step();
        chk("reset busy", int'(o_busy), 0);
        chk("reset done", int'(o_done), 0);
        chk("reset data", int'(o_data), 0);
        rst = 1'b0;
        check_reads(16'h0000, "reset");

        for (int i = 0; i < 4; i++) begin
            load(tbl[i].x, tbl[i].w);
            start_run(1'b0, 1'b0, tbl[i].name);
            check_reads(tbl[i].exp, tbl[i].name);
        end

        // Start and writes during COMPUTE must be dropped.
        load(tbl[0].x, tbl[0].w);
        start_run(1'b1, 1'b0, "guard");
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("guard idle busy%0d", k), int'(o_busy), 0);
        end
        check_reads(16'h0005, "guard");
        start_run(1'b0, 1'b0, "rerun");
        check_reads(16'h0005, "rerun");

        // Start in the IDLE cycle directly after DONE.
        start_run(1'b0, 1'b0, "b2b1");
        start_run(1'b0, 1'b0, "b2b2");
        check_reads(16'h0005, "b2b");

        // Input write in the same cycle as start is used by the computation.
        load(tbl[0].x, tbl[0].w);
        start_run(1'b0, 1'b1, "samewr");
        check_reads(16'h0009, "samewr");

        for (int it = 0; it < 12; it++) begin
            for (int r = 0; r < XS; r++) rx[4*r +: 4] = 4'($urandom_range(0, 15));
            for (int k = 0; k < XS * NC; k++)
                rw[4*k +: 4] = (it % 2 == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            if (it % 3 == 0) rx = rx & 32'h3333_3333;
            load(rx, rw);
            start_run(1'b0, 1'b0, $sformatf("rand%0d", it));
            check_reads(model_exp(), $sformatf("rand%0d", it));
        end

        // Reset in the middle of COMPUTE aborts without committing results.
        load(tbl[0].x, tbl[0].w);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("abort busy", int'(o_busy), 0);
        chk("abort done", int'(o_done), 0);
        rst = 1'b0;
        for (int r = 0; r < XS; r++) xb_m[r] = 0;
        for (int c = 0; c < NC; c++) res_m[c] = 0;
        saw_done = 1'b0;
        saw_busy = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (o_done) saw_done = 1'b1;
            if (o_busy) saw_busy = 1'b1;
        end
        chk("abort done pulse", int'(saw_done), 0);
        chk("abort busy later", int'(saw_busy), 0);
        check_reads(16'h0000, "abort");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
